// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: ball state and per-pixel ball drawing for the pong demo.
// The ball lives on a tile grid (16 px tiles). It steps one tile every
// BALL_SPEED clocks while the game is active, bouncing off the walls, and is
// parked at the centre of the field while the game is idle.
// Optional feature macro: BALL_HIT_COUNT_EN adds o_Hit_Count, a saturating
// count of wall reflections (a corner hit counts twice).
module pong_ball_ctrl #(
  parameter int GAME_WIDTH  = 40,
  parameter int GAME_HEIGHT = 30,
  parameter int BALL_SPEED  = 1250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Game_Active,
  input  logic [9:0] i_Col_Count,
  input  logic [9:0] i_Row_Count,
`ifdef BALL_HIT_COUNT_EN
  output logic [7:0] o_Hit_Count,
`endif
  output logic       o_Draw_Ball,
  output logic [5:0] o_Ball_X,
  output logic [5:0] o_Ball_Y
);

  localparam int         CNT_W    = $clog2(BALL_SPEED);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BALL_SPEED - 1);
  localparam logic [5:0] CENTRE_X = 6'(GAME_WIDTH / 2);
  localparam logic [5:0] CENTRE_Y = 6'(GAME_HEIGHT / 2);
  localparam logic [5:0] LAST_X   = 6'(GAME_WIDTH - 1);
  localparam logic [5:0] LAST_Y   = 6'(GAME_HEIGHT - 1);

  typedef enum logic {IDLE, MOVING} state_t;

  state_t           state, state_nxt;
  logic [5:0]       ball_x, ball_y, x_nxt, y_nxt;
  logic             dir_x, dir_y, dx_nxt, dy_nxt;   // 1 = +1, 0 = -1
  logic [CNT_W-1:0] step_cnt, cnt_nxt;
  logic             step;
  logic [6:0]       x_stepped, y_stepped;           // {new_dir, new_pos}
  logic             hit_x, hit_y;
  logic             draw_ball_p1;

  // One tile step on one axis: reflect at either wall, else move along dir.
  function automatic logic [6:0] axis_step(input logic [5:0] pos,
                                           input logic       dir,
                                           input logic [5:0] last);
    logic [6:0] r;
    if (dir && pos == last)
      r = {1'b0, pos - 1'b1};
    else if (!dir && pos == 6'd0)
      r = {1'b1, 6'd1};
    else if (dir)
      r = {1'b1, pos + 1'b1};
    else
      r = {1'b0, pos - 1'b1};
    return r;
  endfunction

  // Candidate next position/direction for both axes; only used on a step.
  always_comb begin
    x_stepped = axis_step(ball_x, dir_x, LAST_X);
    y_stepped = axis_step(ball_y, dir_y, LAST_Y);
    hit_x     = x_stepped[6] != dir_x;
    hit_y     = y_stepped[6] != dir_y;
  end

  // Next-state logic: centring in IDLE, step timing and motion in MOVING.
  always_comb begin
    state_nxt = state;
    x_nxt     = ball_x;
    y_nxt     = ball_y;
    dx_nxt    = dir_x;
    dy_nxt    = dir_y;
    cnt_nxt   = step_cnt;
    step      = 1'b0;
    case (state)
      IDLE: begin
        x_nxt   = CENTRE_X;
        y_nxt   = CENTRE_Y;
        dx_nxt  = 1'b1;
        dy_nxt  = 1'b1;
        cnt_nxt = '0;
        if (i_Game_Active) state_nxt = MOVING;
      end
      MOVING: begin
        if (!i_Game_Active) begin
          // Abort wins over a pending step: re-centre on the same edge.
          state_nxt = IDLE;
          x_nxt     = CENTRE_X;
          y_nxt     = CENTRE_Y;
          dx_nxt    = 1'b1;
          dy_nxt    = 1'b1;
          cnt_nxt   = '0;
        end else if (step_cnt == CNT_LAST) begin
          cnt_nxt = '0;
          step    = 1'b1;
          x_nxt   = x_stepped[5:0];
          dx_nxt  = x_stepped[6];
          y_nxt   = y_stepped[5:0];
          dy_nxt  = y_stepped[6];
        end else begin
          cnt_nxt = step_cnt + 1'b1;
        end
      end
    endcase
  end

  // Ball state registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state    <= IDLE;
      ball_x   <= CENTRE_X;
      ball_y   <= CENTRE_Y;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ball_x   <= x_nxt;
      ball_y   <= y_nxt;
      dir_x    <= dx_nxt;
      dir_y    <= dy_nxt;
      step_cnt <= cnt_nxt;
    end
  end

  // Stage p1: pixel-in-ball-tile flag, compared against the pre-edge position.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      draw_ball_p1 <= 1'b0;
    else
      draw_ball_p1 <= (i_Col_Count[9:4] == ball_x) && (i_Row_Count[9:4] == ball_y);
  end

  assign o_Draw_Ball = draw_ball_p1;
  assign o_Ball_X    = ball_x;
  assign o_Ball_Y    = ball_y;

`ifdef BALL_HIT_COUNT_EN
  logic [7:0] hit_cnt;

  // Saturating add of 0..2 reflections to the 8-bit hit counter.
  function automatic logic [7:0] sat_add(input logic [7:0] cnt,
                                         input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Reflection counter: cleared whenever idle, bumped on step edges.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      hit_cnt <= 8'd0;
    else if (state == IDLE || state_nxt == IDLE)
      hit_cnt <= 8'd0;
    else if (step)
      hit_cnt <= sat_add(hit_cnt, {1'b0, hit_x} + {1'b0, hit_y});
  end

  assign o_Hit_Count = hit_cnt;
`endif

endmodule
